mem_port_arbiter: RTL and testbench

Two-master arbiter that shares the single CPU memory port (the `mem_addr` / `mem_wdata` / `mem_we` / `mem_re` / `mem_rdata` / `mem_ready` path feeding the AXI4-Lite manager and the peripheral bus controller) between the instruction-fetch port and the data port of the core. It serialises requests, applies round-robin or fixed priority, and routes the response back to the winner. A timeout counter aborts transactions whose downstream `ready` never arrives, so the core cannot hang on an unmapped address.

---
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between the fetch and data ports.
// Round-robin or fixed priority, with a saturating abort timeout.
module mem_port_arbiter #(
  parameter int RR      = 1,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_err,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_we,
  output logic        m_re,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic [1:0]  grant
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO   = CW'(TIMEOUT);
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          r_last_d;
  logic [CW-1:0] r_cnt;
  logic          w_any;
  logic          w_pick_d;
  logic          w_tout;
  logic          w_wr;

  assign w_any    = i_req | d_req;
  // data wins unless fetch also asks and data was served last
  assign w_pick_d = d_req & (~i_req | (RR == 0) | ~r_last_d);
  assign w_tout   = (TIMEOUT != 0) && (r_cnt == TO);
  assign w_wr     = w_pick_d & d_we;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_next = S_BUSY;
      S_BUSY:  if (m_ready || w_tout) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_d <= 1'b0;
      r_cnt    <= '0;
      grant    <= 2'b00;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_we     <= 1'b0;
      m_re     <= 1'b0;
      i_rdata  <= '0;
      i_ready  <= 1'b0;
      i_err    <= 1'b0;
      d_rdata  <= '0;
      d_ready  <= 1'b0;
      d_err    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            grant   <= w_pick_d ? 2'b10 : 2'b01;
            m_addr  <= w_pick_d ? d_addr : i_addr;
            m_wdata <= w_pick_d ? d_wdata : '0;
            m_we    <= w_wr;
            m_re    <= ~w_wr;
            r_cnt   <= '0;
          end
        end
        S_BUSY: begin
          if (m_ready || w_tout) begin
            m_we <= 1'b0;
            m_re <= 1'b0;
            // a real completion beats a same-cycle timeout
            if (grant[1]) begin
              d_ready <= 1'b1;
              d_err   <= ~m_ready;
              d_rdata <= m_ready ? m_rdata : '0;
            end else begin
              i_ready <= 1'b1;
              i_err   <= ~m_ready;
              i_rdata <= m_ready ? m_rdata : '0;
            end
          end else if (r_cnt != CMAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          i_ready  <= 1'b0;
          i_err    <= 1'b0;
          d_ready  <= 1'b0;
          d_err    <= 1'b0;
          r_last_d <= grant[1];
          grant    <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed plan steps plus random traffic
// checked against a transaction-level queue model.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] resp;
    int          dly;
  } txn_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, d_req, d_we, m_ready;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic        sel;

  logic [31:0] a_i_rdata, a_d_rdata, a_m_addr, a_m_wdata;
  logic        a_i_ready, a_i_err, a_d_ready, a_d_err, a_m_we, a_m_re;
  logic [1:0]  a_grant;
  logic [31:0] b_i_rdata, b_d_rdata, b_m_addr, b_m_wdata;
  logic        b_i_ready, b_i_err, b_d_ready, b_d_err, b_m_we, b_m_re;
  logic [1:0]  b_grant;

  logic [31:0] o_i_rdata, o_d_rdata, o_m_addr, o_m_wdata;
  logic        o_i_ready, o_i_err, o_d_ready, o_d_err, o_m_we, o_m_re;
  logic [1:0]  o_grant;

  txn_t iq[$];
  txn_t dq[$];
  bit   order[$];
  bit   m_last_d;
  bit   rr_mode;
  logic [31:0] m_ird, m_drd;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RR(1), .TIMEOUT(TO)) u_rr (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(a_i_rdata),
    .i_ready(a_i_ready), .i_err(a_i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(a_d_rdata), .d_ready(a_d_ready), .d_err(a_d_err),
    .m_addr(a_m_addr), .m_wdata(a_m_wdata), .m_we(a_m_we), .m_re(a_m_re),
    .m_rdata(m_rdata), .m_ready(m_ready), .grant(a_grant)
  );

  mem_port_arbiter #(.RR(0), .TIMEOUT(TO)) u_fp (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(b_i_rdata),
    .i_ready(b_i_ready), .i_err(b_i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(b_d_rdata), .d_ready(b_d_ready), .d_err(b_d_err),
    .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_we(b_m_we), .m_re(b_m_re),
    .m_rdata(m_rdata), .m_ready(m_ready), .grant(b_grant)
  );

  assign o_i_rdata = sel ? b_i_rdata : a_i_rdata;
  assign o_d_rdata = sel ? b_d_rdata : a_d_rdata;
  assign o_m_addr  = sel ? b_m_addr  : a_m_addr;
  assign o_m_wdata = sel ? b_m_wdata : a_m_wdata;
  assign o_i_ready = sel ? b_i_ready : a_i_ready;
  assign o_i_err   = sel ? b_i_err   : a_i_err;
  assign o_d_ready = sel ? b_d_ready : a_d_ready;
  assign o_d_err   = sel ? b_d_err   : a_d_err;
  assign o_m_we    = sel ? b_m_we    : a_m_we;
  assign o_m_re    = sel ? b_m_re    : a_m_re;
  assign o_grant   = sel ? b_grant   : a_grant;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    i_req = (iq.size() != 0);
    d_req = (dq.size() != 0);
    i_addr  = 32'h0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
    d_we    = 1'b0;
    if (iq.size() != 0) i_addr = iq[0].addr;
    if (dq.size() != 0) begin
      d_addr  = dq[0].addr;
      d_wdata = dq[0].wdata;
      d_we    = dq[0].we;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rdy"}, {o_i_ready, o_d_ready, o_i_err, o_d_err}, 0);
    chk({tag, "_grant"}, o_grant, 0);
    chk({tag, "_strb"}, {o_m_re, o_m_we}, 0);
    chk({tag, "_ird"}, o_i_rdata, m_ird);
    chk({tag, "_drd"}, o_d_rdata, m_drd);
  endtask

  // Called on a falling edge with the arbiter idle and requests driven.
  task automatic do_txn();
    bit wd;
    txn_t t;
    int nb;
    logic [31:0] exp;
    wd = (dq.size() != 0) &&
         ((iq.size() == 0) || !rr_mode || !m_last_d);
    t = wd ? dq[0] : iq[0];
    if (!wd) begin
      t.we = 1'b0;
      t.wdata = 32'h0;
    end
    nb = (t.dly != 0) ? t.dly : TO + 1;
    @(negedge clk);
    for (int j = 1; j <= nb; j++) begin
      chk("busy_grant", o_grant, wd ? 2 : 1);
      chk("busy_m_re", o_m_re, !t.we);
      chk("busy_m_we", o_m_we, t.we);
      chk("busy_m_addr", o_m_addr, t.addr);
      chk("busy_m_wdata", o_m_wdata, t.wdata);
      chk("busy_rdy", {o_i_ready, o_d_ready}, 0);
      m_ready = (j == t.dly);
      m_rdata = m_ready ? t.resp : $urandom;
      @(negedge clk);
    end
    m_ready = 1'b0;
    m_rdata = $urandom;
    exp = (t.dly != 0) ? t.resp : 32'h0;
    if (wd) m_drd = exp;
    else m_ird = exp;
    chk("resp_i_ready", o_i_ready, !wd);
    chk("resp_d_ready", o_d_ready, wd);
    chk("resp_i_err", o_i_err, !wd && t.dly == 0);
    chk("resp_d_err", o_d_err, wd && t.dly == 0);
    chk("resp_i_rdata", o_i_rdata, m_ird);
    chk("resp_d_rdata", o_d_rdata, m_drd);
    chk("resp_strb", {o_m_re, o_m_we}, 0);
    m_last_d = wd;
    order.push_back(wd);
    if (wd) void'(dq.pop_front());
    else void'(iq.pop_front());
    drive_inputs();
    @(negedge clk);
    chk("idle_rdy", {o_i_ready, o_d_ready, o_i_err, o_d_err}, 0);
    chk("idle_grant", o_grant, 0);
    chk("idle_strb", {o_m_re, o_m_we}, 0);
  endtask

  task automatic run();
    drive_inputs();
    while (iq.size() != 0 || dq.size() != 0) do_txn();
  endtask

  task automatic push(input bit to_d, input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] r,
                      input int dly);
    txn_t t;
    t.we = we;
    t.addr = a;
    t.wdata = wd;
    t.resp = r;
    t.dly = dly;
    if (to_d) dq.push_back(t);
    else iq.push_back(t);
  endtask

  task automatic push_rand(input bit to_d);
    push(to_d, 1'($urandom), $urandom, $urandom, $urandom,
         $urandom_range(0, 5));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    iq.delete();
    dq.delete();
    drive_inputs();
    m_ready = 1'b0;
    m_ird = 32'h0;
    m_drd = 32'h0;
    m_last_d = 1'b0;
    #1;
    chk("rst_ird", o_i_rdata, 0);
    chk("rst_drd", o_d_rdata, 0);
    chk("rst_m_addr", o_m_addr, 0);
    chk("rst_m_wdata", o_m_wdata, 0);
    chk("rst_ctrl", {o_i_ready, o_i_err, o_d_ready, o_d_err,
                     o_m_we, o_m_re, o_grant}, 0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic stray();
    m_ready = 1'b1;
    m_rdata = $urandom;
    @(negedge clk);
    m_ready = 1'b0;
    chk_quiet("stray1");
    @(negedge clk);
    chk_quiet("stray2");
  endtask

  task automatic chk_order(input string tag, input int n,
                           input logic [7:0] exp);
    logic [7:0] got;
    got = '0;
    for (int k = 0; k < n && k < order.size(); k++) got[k] = order[k];
    chk({tag, "_len"}, order.size(), n);
    chk(tag, got, exp);
  endtask

  initial begin
    sel = 1'b0;
    rr_mode = 1'b1;
    m_rdata = 32'h0;
    @(negedge clk);
    do_reset();

    push(1, 1, 32'h4000_0000, 32'hCAFE_F00D, 32'h1234_5678, 1);
    run();
    push(0, 0, 32'h0000_0100, 32'h0, 32'h0000_0013, 2);
    run();

    order.delete();
    for (int k = 0; k < 2; k++) begin
      push_rand(0);
      push_rand(1);
    end
    run();
    chk_order("rr_order", 4, 8'b0101);

    push(1, 0, 32'h2000_0000, 32'h5555_AAAA, 32'hDEAD_BEEF, 0);
    run();
    push(1, 0, 32'h2000_0004, 32'h0, 32'h0BAD_F00D, 5);
    run();
    stray();

    push(1, 1, 32'h0000_0040, 32'h1, 32'h2, 1);
    run();
    push(0, 0, 32'h0000_0200, 32'h0, 32'h3, 5);
    drive_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy_m_re", o_m_re, 1);
    do_reset();
    order.delete();
    push_rand(0);
    push_rand(1);
    run();
    chk_order("post_rst_order", 2, 8'b01);

    for (int it = 0; it < 40; it++) begin
      int r;
      r = $urandom_range(1, 3);
      if (r[0]) push_rand(0);
      if (r[1]) push_rand(1);
      if ($urandom_range(0, 3) == 0) push_rand(r[1]);
      run();
      if ($urandom_range(0, 3) == 0) stray();
    end

    sel = 1'b1;
    rr_mode = 1'b0;
    do_reset();
    order.delete();
    for (int k = 0; k < 3; k++) push_rand(1);
    push_rand(0);
    run();
    chk_order("fp_order", 4, 8'b0111);
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 1) == 1) push_rand(0);
      push_rand(1);
      if ($urandom_range(0, 1) == 1) push_rand(1);
      run();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
